// File: rtl/uart_word_decoder.sv
// Assembles 10-byte UART load frames (start, 4 addr, 4 data, end) into single-cycle
// word-write strobes, with resync on bad frames, inter-byte timeout and error counting.
module uart_word_decoder #(
    parameter int                       WIDTH_A        = 32,
    parameter int                       WIDTH_D        = 32,
    parameter logic [7:0]               START_BYTE     = 8'haa,
    parameter logic [7:0]               END_BYTE       = 8'h55,
    parameter int                       TIMEOUT_WIDTH  = 16,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = TIMEOUT_WIDTH'(50000)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [WIDTH_A-1:0] addr,
    output logic [WIDTH_D-1:0] data,
    output logic               we,
    output logic               busy,
    output logic               frame_error,
    output logic               timeout_error,
    output logic [7:0]         err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_END
    } state_t;

    state_t                   state_q;
    logic [1:0]               idx_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_d;
    logic                     tmo_hit;
    logic [WIDTH_A-1:0]       shift_addr_q;
    logic [WIDTH_D-1:0]       shift_data_q;
    logic [WIDTH_A-1:0]       addr_q;
    logic [WIDTH_D-1:0]       data_q;
    logic                     we_q;
    logic                     frame_error_q;
    logic                     timeout_error_q;
    logic [7:0]               err_count_q;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

    // A byte arriving in the expiry cycle wins over the timeout.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q + TIMEOUT_WIDTH'(1);
        tmo_hit   = (TIMEOUT_CYCLES != '0) && (state_q != S_IDLE) && !rx_valid
                    && (tmo_cnt_d == TIMEOUT_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            tmo_cnt_q       <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            we_q            <= 1'b0;
            frame_error_q   <= 1'b0;
            timeout_error_q <= 1'b0;
            err_count_q     <= '0;
        end else begin
            we_q            <= 1'b0;
            frame_error_q   <= 1'b0;
            timeout_error_q <= 1'b0;

            if (state_q == S_IDLE || rx_valid) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_d;
            end

            if (tmo_hit) begin
                state_q         <= S_IDLE;
                idx_q           <= '0;
                tmo_cnt_q       <= '0;
                timeout_error_q <= 1'b1;
                err_count_q     <= sat_inc8(err_count_q);
            end else if (rx_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_data == START_BYTE) begin
                            state_q <= S_ADDR;
                            idx_q   <= '0;
                        end
                    end
                    S_ADDR: begin
                        shift_addr_q[8*idx_q +: 8] <= rx_data;
                        idx_q                      <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_data_q[8*idx_q +: 8] <= rx_data;
                        idx_q                      <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= S_END;
                            idx_q   <= '0;
                        end
                    end
                    S_END: begin
                        // A start byte here is just a bad terminator; no resync into a new frame.
                        if (rx_data == END_BYTE) begin
                            addr_q <= shift_addr_q;
                            data_q <= shift_data_q;
                            we_q   <= 1'b1;
                        end else begin
                            frame_error_q <= 1'b1;
                            err_count_q   <= sat_inc8(err_count_q);
                        end
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign addr          = addr_q;
    assign data          = data_q;
    assign we            = we_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_error   = frame_error_q;
    assign timeout_error = timeout_error_q;
    assign err_count     = err_count_q;

endmodule

// File: doc/uart_word_decoder.md
Name: uart_word_decoder

Overview:
- Consumes the byte stream from the SoC's UART receiver and assembles 10-byte load frames into single-cycle word-write commands.
- Frame format: 0xAA start byte, 4 address bytes (LSB first), 4 data bytes (LSB first), 0x55 end byte.
- Downstream logic uses the resulting addr/data/we strobe to:
  - load instruction memory (0x4000..),
  - load data memory (0x0000..),
  - write SoC control registers (0x5000 cpu_reset, 0x5001 resume, 0x5002 bus master).
- Includes frame validation, resync on bad frames, an inter-byte timeout and a saturating error counter.

Parameters:
- WIDTH_A, 32, address width; must be 32 to match the 4 address bytes.
- WIDTH_D, 32, data width; must be 32 to match the 4 data bytes.
- START_BYTE, 8'haa, frame start marker.
- END_BYTE, 8'h55, frame end marker.
- TIMEOUT_WIDTH, 16, width of the inter-byte timeout counter.
- TIMEOUT_CYCLES, 16'd50000, idle clocks allowed between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  received byte, valid when rx_valid=1
- rx_valid  input  1  one-cycle strobe per received byte
- addr  output  WIDTH_A  assembled address; held stable from the we pulse until the next we
- data  output  WIDTH_D  assembled data; held stable from the we pulse until the next we
- we  output  1  one-cycle write strobe for a valid frame
- busy  output  1  high while a frame is in progress (state != S_IDLE)
- frame_error  output  1  one-cycle pulse when the end byte mismatches
- timeout_error  output  1  one-cycle pulse when a frame is aborted by timeout
- err_count  output  8  saturating count of frame_error plus timeout_error events

Behaviour:
- Reset (sync, active-high, one clock) sets:
  - state=S_IDLE, byte index=0, timeout counter=0;
  - addr=0, data=0, we=0, busy=0, frame_error=0, timeout_error=0, err_count=0.
  - Reset mid-frame discards the partial frame with no we and no error pulse.
- States:
  - S_IDLE: on rx_valid with rx_data==START_BYTE go to S_ADDR with idx=0. Any other byte is ignored; no error is raised.
  - S_ADDR: each rx_valid writes rx_data into shift_addr[8*idx +: 8]. After idx==3, go to S_DATA with idx=0.
  - S_DATA: same scheme into shift_data. After idx==3, go to S_END.
  - S_END: on rx_valid:
    - rx_data==END_BYTE: addr<=shift_addr, data<=shift_data, we<=1 for one cycle, go to S_IDLE.
    - otherwise: frame_error<=1 for one cycle, err_count increments, go to S_IDLE. addr/data keep their previous values.
    - An 0xAA received in S_END is a mismatch: error, go to S_IDLE. It does not start a new frame.
- An 0xAA byte inside S_ADDR or S_DATA is payload, not a resync.
- Latency: we/frame_error are asserted on the clock edge after the cycle in which the end byte's rx_valid is sampled (registered outputs, 1 cycle).
- Back-to-back frames: a start byte may arrive in the cycle immediately after the end byte. we may then pulse again 10 bytes later.
- Timeout:
  - In any state other than S_IDLE, the counter increments each clock without rx_valid and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES, with no rx_valid that cycle: state<=S_IDLE, timeout_error<=1 for one cycle, err_count increments.
  - If rx_valid coincides with expiry, the byte wins: it is processed and the counter clears.
  - In S_IDLE the counter is held at 0.
  - TIMEOUT_CYCLES==0 means no timeout ever fires.
- err_count: saturates at 8'hff and never wraps. frame_error and timeout_error cannot occur in the same cycle.
- we, frame_error and timeout_error are mutually exclusive and never asserted for more than one cycle.
- busy = (state != S_IDLE); it is registered, so it rises the cycle after the start byte is sampled.
- The implementation uses no combinational path from rx_* to any output.

Test Plan:
- Frame AA 00 50 00 00 01 00 00 00 55 -> single we pulse with addr=32'h00005000, data=32'h00000001; err_count=0.
- Two back-to-back frames (no gap), 0x4002/0x18000040 then 0x4003/0x00010003 -> two we pulses exactly 10 byte-strobes apart with the correct addr/data; no errors.
- Garbage 12 34 AA, then 00 40 00 00 AA 55 AA 55 5A -> bytes before AA ignored, embedded AA/55 treated as payload; last byte 5A != 55 -> frame_error pulse, no we, addr/data unchanged, err_count=1.
- Start a frame, send 3 address bytes, then stall TIMEOUT_CYCLES (set to 100) -> timeout_error pulse at cycle 100, busy=0, err_count=1. A following full frame decodes correctly.
- Assert reset during S_DATA, then send a full frame -> no we and no error from the partial frame; the full frame decodes and err_count=0.
- Force 300 bad end bytes -> err_count=8'hff (saturated), not wrapped.
